// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG health-test FIFO slice: FSM state
// encoding, alarm cause bit positions and default parameter values.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2
    } trng_state_e;

    localparam int CAUSE_RCT = 0;
    localparam int CAUSE_APT = 1;

    localparam int DEF_DEPTH         = 4;
    localparam int DEF_STARTUP_BYTES = 16;
    localparam int DEF_RCT_CUTOFF    = 4;
    localparam int DEF_APT_WINDOW    = 64;
    localparam int DEF_APT_CUTOFF    = 13;

endpackage

// File: rtl/trng_byte_fifo.sv
// Generic DEPTH x 8 synchronous FIFO with push, pop, synchronous flush,
// full and empty. The head entry is always presented on dout.
module trng_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; flush only rewinds pointers, stale data is unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_health_fifo.sv
// TRNG consumer: pulls bytes with the ready/consume handshake, runs the
// repetition count test and (with TRNG_APT_EN defined) the adaptive
// proportion test, buffers passing bytes in a FIFO and raises a sticky
// alarm on any failure until alarm_clr. Without TRNG_APT_EN only the RCT
// runs and alarm_cause[1] stays 0.
module trng_health_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int STARTUP_BYTES = DEF_STARTUP_BYTES,
    parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW    = DEF_APT_WINDOW,
    parameter int APT_CUTOFF    = DEF_APT_CUTOFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] src_data,
    input  logic       src_ready,
    output logic       src_consume,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       alarm,
    output logic [1:0] alarm_cause,
    input  logic       alarm_clr,
    output logic       trng_en
);

    localparam int SC_W = $clog2(STARTUP_BYTES + 1);
    localparam int RC_W = $clog2(RCT_CUTOFF + 1);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..16");
    end
    if (APT_WINDOW < 2 || APT_WINDOW > 256 || (APT_WINDOW & (APT_WINDOW - 1)) != 0
        || APT_CUTOFF < 1) begin : g_bad_apt
        $error("APT_WINDOW must be a power of two in 2..256, APT_CUTOFF >= 1");
    end

    trng_state_e     state;
    trng_state_e     state_d;
    logic [SC_W-1:0] startup_cnt;
    logic [7:0]      last_byte;
    logic [RC_W-1:0] rct_cnt;
    logic [RC_W-1:0] rct_next;
    logic            accept;
    logic            rct_fail;
    logic            apt_fail;
    logic            fail;
    logic            clr;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [1:0]      cause_q;

    assign accept = src_ready && (state != ST_ALARM) && ((state == ST_STARTUP) || !fifo_full);
    assign clr    = (state == ST_ALARM) && alarm_clr;

    // RCT: rct_cnt == 0 marks "no byte seen yet", so the first byte seeds the run length.
    always_comb begin
        rct_next = RC_W'(1);
        if (rct_cnt != '0 && src_data == last_byte) begin
            rct_next = (rct_cnt == RC_W'(RCT_CUTOFF)) ? rct_cnt : rct_cnt + 1'b1;
        end
        rct_fail = accept && (rct_next == RC_W'(RCT_CUTOFF));
    end

    // RCT state: previous byte and current run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_byte <= '0;
            rct_cnt   <= '0;
        end else if (clr) begin
            last_byte <= '0;
            rct_cnt   <= '0;
        end else if (accept) begin
            last_byte <= src_data;
            rct_cnt   <= rct_next;
        end
    end

`ifdef TRNG_APT_EN
    localparam int AW_W = $clog2(APT_WINDOW);
    localparam int AC_W = $clog2(APT_CUTOFF + 1);

    logic [AW_W-1:0] apt_pos;
    logic [7:0]      apt_ref;
    logic [AC_W-1:0] apt_cnt;
    logic [AC_W-1:0] apt_next;

    // APT: window position 0 latches a new reference counting as occurrence 1.
    always_comb begin
        apt_next = apt_cnt;
        if (apt_pos == '0) begin
            apt_next = AC_W'(1);
        end else if (src_data == apt_ref && apt_cnt != AC_W'(APT_CUTOFF)) begin
            apt_next = apt_cnt + 1'b1;
        end
        apt_fail = accept && (apt_next == AC_W'(APT_CUTOFF));
    end

    // APT state: window position wraps naturally at the power-of-two window length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apt_pos <= '0;
            apt_ref <= '0;
            apt_cnt <= '0;
        end else if (clr) begin
            apt_pos <= '0;
            apt_ref <= '0;
            apt_cnt <= '0;
        end else if (accept) begin
            if (apt_pos == '0) begin
                apt_ref <= src_data;
            end
            apt_cnt <= apt_next;
            apt_pos <= apt_pos + 1'b1;
        end
    end
`else
    assign apt_fail = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_d;
        end
    end

    // Next state, FIFO control and handshake outputs.
    always_comb begin
        state_d     = state;
        fail        = rct_fail || apt_fail;
        push        = accept && (state == ST_RUN) && !fail;
        src_consume = accept;
        alarm       = (state == ST_ALARM);
        trng_en     = (state != ST_ALARM);
        out_valid   = (state == ST_RUN) && !fifo_empty;
        case (state)
            ST_STARTUP: begin
                if (fail) begin
                    state_d = ST_ALARM;
                end else if (accept && startup_cnt == SC_W'(STARTUP_BYTES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fail) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (alarm_clr) begin
                    state_d = ST_STARTUP;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    // Startup byte count and sticky alarm causes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            startup_cnt <= '0;
            cause_q     <= '0;
        end else if (clr) begin
            startup_cnt <= '0;
            cause_q     <= '0;
        end else begin
            if (accept && state == ST_STARTUP) begin
                startup_cnt <= startup_cnt + 1'b1;
            end
            if (fail) begin
                cause_q[CAUSE_RCT] <= cause_q[CAUSE_RCT] | rct_fail;
                cause_q[CAUSE_APT] <= cause_q[CAUSE_APT] | apt_fail;
            end
        end
    end

    assign alarm_cause = cause_q;

    // Flushing on the failing byte empties the FIFO on the same edge that enters ALARM.
    trng_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (out_valid && out_ready),
        .flush (fail),
        .din   (src_data),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
